// File: rtl/ahb_bridge_sequencer.sv
// rtl/ahb_bridge_sequencer.sv - arbitrated single-transfer AHB master front-end for the shared AHB-to-APB bridge
// Build option: define AHB_SEQ_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.

module ahb_bridge_sequencer #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                 HCLK,
   input  logic                 RESET,
   input  logic [N_REQ-1:0]     req,
   input  logic [7*N_REQ-1:0]   req_addr,
   input  logic [N_REQ-1:0]     req_write,
   input  logic [32*N_REQ-1:0]  req_wdata,
   output logic [N_REQ-1:0]     gnt,
   output logic [N_REQ-1:0]     done,
   output logic [N_REQ-1:0]     err,
   output logic [31:0]          rdata,
   output logic                 HSEL,
   output logic                 HWRITE,
   output logic                 HREADY,
   output logic [6:0]           HADDR,
   output logic [31:0]          HWDATA,
   input  logic                 HREADYOUT,
   input  logic [31:0]          HRDATA
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   // One spare width bit when TIMEOUT is 0 so the counter never collapses to zero width
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_DONE,
      ST_ABORT
   } state_t;

   state_t               state_q;
   logic [IDX_W-1:0]     win_q;
   logic                 wr_q;
   logic [31:0]          wdata_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 hsel_q;
   logic                 hwrite_q;
   logic [6:0]           haddr_q;
   logic [31:0]          hwdata_q;
   logic [N_REQ-1:0]     gnt_q;
   logic [N_REQ-1:0]     done_q;
   logic [N_REQ-1:0]     err_q;
   logic [31:0]          rdata_q;

   logic                 win_found_d;
   logic [IDX_W-1:0]     win_idx_d;

   logic [6:0]           addr_arr  [N_REQ];
   logic [31:0]          wdata_arr [N_REQ];

`ifndef AHB_SEQ_FIXED_PRIO_EN
   // Index of the most recent grant; the search for the next winner begins just after it
   logic [IDX_W-1:0]     ptr_q;
`endif

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Split the flattened per-requester buses into indexable arrays
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         addr_arr[i]  = req_addr[7*i +: 7];
         wdata_arr[i] = req_wdata[32*i +: 32];
      end
   end

`ifdef AHB_SEQ_FIXED_PRIO_EN
   // Fixed priority: scan from the top so the lowest pending index is the last one written
   always_comb begin
      win_found_d = 1'b0;
      win_idx_d   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[IDX_W'(i)]) begin
            win_found_d = 1'b1;
            win_idx_d   = IDX_W'(i);
         end
      end
   end
`else
   // Round-robin: first pending requester after the last grant, wrapping modulo N_REQ
   always_comb begin
      logic [IDX_W-1:0] cand;
      win_found_d = 1'b0;
      win_idx_d   = '0;
      cand        = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IDX_W'((int'(ptr_q) + k) % N_REQ);
         if (!win_found_d && req[cand]) begin
            win_found_d = 1'b1;
            win_idx_d   = cand;
         end
      end
   end
`endif

   // Transfer sequencer: arbitration, address phase, data phase with timeout, status pulse
   always_ff @(posedge HCLK) begin
      if (RESET) begin
         state_q  <= ST_IDLE;
         win_q    <= '0;
         wr_q     <= 1'b0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         hsel_q   <= 1'b0;
         hwrite_q <= 1'b0;
         haddr_q  <= '0;
         hwdata_q <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         err_q    <= '0;
         rdata_q  <= '0;
`ifndef AHB_SEQ_FIXED_PRIO_EN
         ptr_q    <= IDX_W'(N_REQ - 1);
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (win_found_d) begin
                  state_q  <= ST_ADDR;
                  win_q    <= win_idx_d;
                  wr_q     <= req_write[win_idx_d];
                  wdata_q  <= wdata_arr[win_idx_d];
                  hsel_q   <= 1'b1;
                  haddr_q  <= addr_arr[win_idx_d];
                  hwrite_q <= req_write[win_idx_d];
                  gnt_q    <= onehot(win_idx_d);
`ifndef AHB_SEQ_FIXED_PRIO_EN
                  ptr_q    <= win_idx_d;
`endif
               end
            end
            ST_ADDR: begin
               state_q  <= ST_DATA;
               hsel_q   <= 1'b0;
               hwdata_q <= wr_q ? wdata_q : 32'h0;
               cnt_q    <= '0;
            end
            ST_DATA: begin
               // A ready response always wins over an expiring counter in the same cycle
               if (HREADYOUT) begin
                  if (!wr_q) begin
                     rdata_q <= HRDATA;
                  end
                  done_q  <= onehot(win_q);
                  state_q <= ST_DONE;
               end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT))) begin
                  err_q   <= onehot(win_q);
                  state_q <= ST_ABORT;
               end else if (cnt_q != '1) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               done_q  <= '0;
               gnt_q   <= '0;
               state_q <= ST_IDLE;
            end
            ST_ABORT: begin
               err_q   <= '0;
               gnt_q   <= '0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // HREADY follows the bridge during the data phase so it sees the bus stall; otherwise idle-high
   assign HREADY = (state_q == ST_DATA) ? HREADYOUT : 1'b1;
   assign HSEL   = hsel_q;
   assign HWRITE = hwrite_q;
   assign HADDR  = haddr_q;
   assign HWDATA = hwdata_q;
   assign gnt    = gnt_q;
   assign done   = done_q;
   assign err    = err_q;
   assign rdata  = rdata_q;

endmodule

// File: doc/ahb_bridge_sequencer.md
# ahb_bridge_sequencer

Front-end controller sharing the single AHB-to-APB bridge among up to N_REQ local requesters. It arbitrates pending requests, then drives one complete AHB transfer at a time into the bridge: a one-cycle address phase, then a data phase held until the bridge returns HREADYOUT. It returns read data, completion and timeout status to the granted requester. It sits between the requester logic and the bridge's AHB slave port.

## Interface
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT, 16, max data-phase wait cycles before abort (0 = never abort)
- HCLK  in  1  bus clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- req  in  N_REQ  request level per requester, held until its done/err pulse
- req_addr  in  7*N_REQ  per requester {slave_sel[1:0], paddr[4:0]}, slice i = [7i+6:7i]
- req_write  in  N_REQ  1 = write, 0 = read
- req_wdata  in  32*N_REQ  write data, slice i = [32i+31:32i]
- gnt  out  N_REQ  one-hot, high from address phase through DONE/ABORT cycle
- done  out  N_REQ  one-cycle completion pulse to granted requester
- err  out  N_REQ  one-cycle timeout pulse to granted requester
- rdata  out  32  read data, valid with done
- HSEL, HWRITE, HREADY  out  1  to bridge
- HADDR  out  7  to bridge
- HWDATA  out  32  to bridge
- HREADYOUT  in  1  from bridge
- HRDATA  in  32  from bridge

## Operation
- States: IDLE, ADDR, DATA, DONE, ABORT.
- IDLE: if any req bit high, latch winner index, its addr/write/wdata; go ADDR. Else stay.
- ADDR (exactly one cycle): HSEL=1, HADDR=latched addr, HWRITE=latched write, HREADY=1; go DATA.
- DATA: HSEL=0, HWDATA=latched wdata (writes; 0 for reads), HREADY=HREADYOUT (combinational pass-through). On HREADYOUT=1: capture HRDATA into rdata if read; go DONE. Else increment wait counter; if TIMEOUT!=0 and counter reaches TIMEOUT, go ABORT.
- DONE: done[winner]=1 for one cycle; go IDLE.
- ABORT: err[winner]=1 for one cycle, rdata unchanged; go IDLE. Bridge is not reset; the requester is responsible for recovery.
- Arbitration: round-robin. Search starts at last-granted index + 1, wrapping modulo N_REQ. Pointer updates only on entry to ADDR. After reset the pointer equals N_REQ-1, so requester 0 wins first.
- Requests arriving or dropping outside IDLE are ignored until the next IDLE cycle. Dropping req while granted is illegal; the transfer completes regardless.
- Wait counter: $clog2(TIMEOUT+1) bits, cleared on entry to DATA, saturates.
- Reset in any state: next cycle is IDLE with all outputs at reset values. An in-flight transfer is dropped with no done/err.

## Timing
- Reset values: HSEL=0, HWRITE=0, HREADY=1, HADDR=0, HWDATA=0, gnt=0, done=0, err=0, rdata=0, state IDLE, RR pointer N_REQ-1.
- All outputs are registered except HREADY in DATA.
- req seen high at edge k (IDLE): ADDR in cycle k+1, DATA from k+2.
- HREADYOUT high in DATA at edge m: done pulse in cycle m+1, IDLE at m+2.
- Minimum transfer (zero wait): 4 cycles req-to-done, 1 idle cycle between back-to-back transfers.
- Timeout: err pulses TIMEOUT+1 cycles after DATA entry if HREADYOUT never rises. HREADYOUT=1 on the final counted cycle has priority, giving DONE.

## Configuration
- AHB_SEQ_FIXED_PRIO_EN defined: fixed priority, lowest index wins. The RR pointer is not implemented.
- Not defined: round-robin as above.

## Test plan
- Reset: hold RESET 3 cycles mid-DATA -> all outputs at reset values, no done/err; next req[0] is granted first.
- Single write: req[1]=1, addr 7'h25, wdata 32'hDEADBEEF, HREADYOUT=1 -> HSEL high one cycle with HADDR=7'h25, HWRITE=1; HWDATA=32'hDEADBEEF next cycle; done[1] pulses 4 cycles after req.
- Read with wait states: req[2] read addr 7'h41; HREADYOUT low 3 DATA cycles then high with HRDATA=32'h12345678 -> HREADY mirrors HREADYOUT, done[2] with rdata=32'h12345678.
- Round-robin: req=4'b1111 held, zero wait -> grant order 0,1,2,3,0. Under AHB_SEQ_FIXED_PRIO_EN -> 0,0,0.
- Timeout: TIMEOUT=16, HREADYOUT stuck 0 -> err pulses 17 cycles after DATA entry, rdata unchanged. HREADYOUT rising on the 16th wait cycle -> done, not err.
- Late request: req[3] asserted during DATA of req[0] -> ignored until IDLE, then granted with 1 idle cycle gap.
